// File: rtl/fb_ifetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fb_ifetch_pkg                                               |
// | Brief  : Shared widths, reset PC default and fetch-FSM state         |
// |          encodings for the instruction-fetch stage.                  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package fb_ifetch_pkg;

  localparam int FB_32BITS     = 32;
  localparam int FB_IF_STATE_W = 3;

  localparam logic [FB_32BITS-1:0] FB_RESET_PC = 32'h0000_0000;

  // IDLE : post-reset bubble before the first request
  // REQ  : request pulse to instruction memory
  // WAIT : one request outstanding, response may be delivered directly
  // HOLD : response captured in the buffer while IF/ID is locked
  // DROP : stale request outstanding after a redirect, response discarded
  typedef enum logic [FB_IF_STATE_W-1:0] {
    FB_IF_IDLE = 3'd0,
    FB_IF_REQ  = 3'd1,
    FB_IF_WAIT = 3'd2,
    FB_IF_HOLD = 3'd3,
    FB_IF_DROP = 3'd4
  } fb_if_state_e;

endpackage : fb_ifetch_pkg
`default_nettype wire

// File: rtl/fb_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fb_ifetch                                                   |
// | Brief  : Instruction-fetch stage. Owns the word-addressed PC, keeps  |
// |          at most one request outstanding to a variable-latency       |
// |          instruction memory, delivers {pc, pc+1, inst} into IF/ID,   |
// |          honours the hazard lock and drops work on redirects.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fb_ifetch
  import fb_ifetch_pkg::*;
#(
  parameter logic [FB_32BITS-1:0] RESET_PC = FB_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lock,
  input  logic                 redirect_valid,
  input  logic [FB_32BITS-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [FB_32BITS-1:0] imem_addr,
  input  logic                 imem_rvalid,
  input  logic [FB_32BITS-1:0] imem_rdata,
  output logic                 if_we,
  output logic [FB_32BITS-1:0] if_pc,
  output logic [FB_32BITS-1:0] if_pc_add_1,
  output logic [FB_32BITS-1:0] if_inst,
  output logic                 if_flush
);

  fb_if_state_e         state;
  fb_if_state_e         state_nxt;
  logic [FB_32BITS-1:0] pc_q;
  logic [FB_32BITS-1:0] pc_nxt;
  logic [FB_32BITS-1:0] pc_inc;
  logic [FB_32BITS-1:0] inst_buf;
  logic [FB_32BITS-1:0] inst_buf_nxt;

  // Modulo-2^32 increment: 32'hFFFF_FFFF wraps to zero by design
  assign pc_inc = pc_q + 32'd1;

  // PC and link value always track pc_q; the flush is a pure pass-through
  assign imem_addr   = pc_q;
  assign if_pc       = pc_q;
  assign if_pc_add_1 = pc_inc;
  assign if_flush    = redirect_valid;

  // State, PC and instruction buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FB_IF_IDLE;
      pc_q     <= RESET_PC;
      inst_buf <= '0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      inst_buf <= inst_buf_nxt;
    end
  end

  // Next-state and output decode; redirect outranks lock and rvalid everywhere
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    inst_buf_nxt = inst_buf;
    imem_req     = 1'b0;
    if_we        = 1'b0;
    if_inst      = inst_buf;

    case (state)
      FB_IF_IDLE: begin
        state_nxt = FB_IF_REQ;
      end

      FB_IF_REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          // The request is already on the bus, so its response must be eaten
          pc_nxt    = redirect_pc;
          state_nxt = FB_IF_DROP;
        end else begin
          state_nxt = FB_IF_WAIT;
        end
      end

      FB_IF_WAIT: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = imem_rvalid ? FB_IF_REQ : FB_IF_DROP;
        end else if (imem_rvalid) begin
          if (lock) begin
            inst_buf_nxt = imem_rdata;
            state_nxt    = FB_IF_HOLD;
          end else begin
            // Bypass the buffer so delivery adds no latency
            if_we     = 1'b1;
            if_inst   = imem_rdata;
            pc_nxt    = pc_inc;
            state_nxt = FB_IF_REQ;
          end
        end
      end

      FB_IF_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = FB_IF_REQ;
        end else if (!lock) begin
          if_we     = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = FB_IF_REQ;
        end
      end

      FB_IF_DROP: begin
        // Latest redirect wins; the stale response only releases the FSM
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
        end
        if (imem_rvalid) begin
          state_nxt = FB_IF_REQ;
        end
      end

      default: begin
        state_nxt = FB_IF_IDLE;
      end
    endcase
  end

endmodule : fb_ifetch
`default_nettype wire
